serial_adder: RTL

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operand pair SLICE bits per clock through a chain of full-adder cells, with a registered carry between slices. It is the sequential successor to the single-bit full adder in the combinational library. It serves datapaths that trade latency for area and need a start/busy/done handshake, add/subtract mode and signed overflow.

---
 rtl/serial_adder.sv | 113 +++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle add/subtract, SLICE bits per clock
// with a registered carry between slices and start/busy/done handshake.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / SLICE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [IW-1:0] LAST = IW'(N - 1);

    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic             ovf_q;

    logic [SW-1:0]    shift;
    logic [SLICE-1:0] a_s;
    logic [SLICE-1:0] b_s;
    logic [SLICE-1:0] s_s;
    logic [SLICE:0]   c;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] sum_next;
    logic             accept;
    logic             last;

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (idx == LAST);

    // Ripple of SLICE full-adder cells on the current slice, merged into sum.
    always_comb begin
        shift = SW'(idx) * SW'(SLICE);
        a_s   = SLICE'(a_q >> shift);
        b_s   = SLICE'(b_q >> shift);
        c     = '0;
        s_s   = '0;
        c[0]  = carry;
        for (int i = 0; i < SLICE; i++) begin
            s_s[i]   = a_s[i] ^ b_s[i] ^ c[i];
            c[i+1]   = (a_s[i] & b_s[i]) | (c[i] & (a_s[i] ^ b_s[i]));
        end
        mask     = WIDTH'({SLICE{1'b1}});
        sum_next = (sum_q & ~(mask << shift))
                 | (WIDTH'(s_s) << shift);
    end

    // Control FSM and datapath registers; subtract is a + ~b + ~borrow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            state <= RUN;
            idx   <= '0;
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= cin ^ sub;
            sum_q <= '0;
        end else begin
            case (state)
                RUN: begin
                    sum_q <= sum_next;
                    carry <= c[SLICE];
                    if (last) begin
                        cout_q <= c[SLICE];
                        ovf_q  <= c[SLICE] ^ c[SLICE-1];
                        state  <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
